// File: rtl/runway_pkg.sv
// Shared wind-mode encoding used by the input conditioner and the runway FSM.
package runway_pkg;

  typedef enum logic [1:0] {
    MODE_CALM    = 2'b00,
    MODE_RIGHT   = 2'b01,
    MODE_LEFT    = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_e;

  // Only 11 is not a usable wind mode.
  function automatic logic is_legal(mode_e m);
    return (m != MODE_ILLEGAL);
  endfunction

endpackage : runway_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, synchronous active-low reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // Shift the raw level through two stages to settle metastability.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule : sync_2ff

// File: rtl/runway_input_conditioner.sv
// Wind-mode switch debouncer/validator and tick edge detector for the runway FSM.
// A switch code must sit unchanged in the synchronizer output for
// DEBOUNCE_CYCLES edges after it becomes the candidate before it is accepted.
module runway_input_conditioner
  import runway_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  input  logic       tick_in,
  output logic [1:0] mode,
  output logic       step,
  output logic       restart,
  output logic       err
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync2;
  mode_e         sync2_mode;

  mode_e         cand_q,    cand_d;
  logic [CW-1:0] count_q,   count_d;
  mode_e         mode_q,    mode_d;
  logic          restart_q, restart_d;
  logic          err_q,     err_d;
  logic          step_q,    step_d;
  logic          tick_q;
  logic          armed_q;
  logic          accept;

  sync_2ff #(
    .WIDTH (2)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (sw_raw),
    .q_o    (sync2)
  );

  assign sync2_mode = mode_e'(sync2);

  // Debounce, validate the accepted code and derive the one-cycle pulses.
  always_comb begin
    cand_d    = cand_q;
    count_d   = count_q;
    mode_d    = mode_q;
    restart_d = 1'b0;
    err_d     = err_q;
    accept    = 1'b0;

    if (sync2_mode != cand_q) begin
      cand_d  = sync2_mode;
      count_d = '0;
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + 1'b1;
    end else begin
      // Count saturates, so a stable code is re-accepted every edge; that is
      // harmless because repeats of the current mode produce no restart.
      accept = 1'b1;
    end

    if (accept) begin
      if (is_legal(cand_q)) begin
        err_d = 1'b0;
        if (cand_q != mode_q) begin
          mode_d    = cand_q;
          restart_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    // Restart wins over a coincident tick edge; the dropped step is not kept.
    // armed_q masks the first edge after reset, when tick_q is not yet valid.
    step_d = tick_in & ~tick_q & armed_q & ~restart_d;
  end

  // All state and outputs registered, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cand_q    <= MODE_CALM;
      count_q   <= '0;
      mode_q    <= MODE_CALM;
      restart_q <= 1'b0;
      err_q     <= 1'b0;
      step_q    <= 1'b0;
      tick_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      restart_q <= restart_d;
      err_q     <= err_d;
      step_q    <= step_d;
      tick_q    <= tick_in;
      armed_q   <= 1'b1;
    end
  end

  assign mode    = mode_q;
  assign step    = step_q;
  assign restart = restart_q;
  assign err     = err_q;

endmodule : runway_input_conditioner
